// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite engine: colour/sync fields,
// the 16-entry sprite palette and the PMOD pin-order packing helper.
package vga_pkg;

   typedef logic [5:0] colour_t;

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
   } sync_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   localparam colour_t PALETTE [16] = '{
      6'h00, 6'h30, 6'h0C, 6'h03, 6'h3C, 6'h33, 6'h0F, 6'h3F,
      6'h15, 6'h2A, 6'h10, 6'h04, 6'h01, 6'h14, 6'h05, 6'h11
   };

   // PMOD connector order: {hsync,b0,g0,r0,vsync,b1,g1,r1}
   function automatic logic [7:0] pmod_pack(input rgb_t c, input sync_t s);
      return {s.hsync, c.b[0], c.g[0], c.r[0], s.vsync, c.b[1], c.g[1], c.r[1]};
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with sync, active-area and end-of-frame decode.
module vga_timing #(
   parameter  int H_ACTIVE = 640,
   parameter  int H_FP     = 16,
   parameter  int H_SYNC   = 96,
   parameter  int H_BP     = 48,
   parameter  int V_ACTIVE = 480,
   parameter  int V_FP     = 10,
   parameter  int V_SYNC   = 2,
   parameter  int V_BP     = 33,
   localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW       = $clog2(HT + 1),
   localparam int YW       = $clog2(VT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          hsync_on,
   output logic          vsync_on,
   output logic          active,
   output logic          end_of_frame
);

   always_ff @(posedge clk) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (x == XW'(HT - 1)) begin
         x <= '0;
         y <= (y == YW'(VT - 1)) ? '0 : y + 1'b1;
      end else begin
         x <= x + 1'b1;
      end
   end

   assign hsync_on     = (x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC));
   assign vsync_on     = (y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC));
   assign active       = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
   assign end_of_frame = (x == XW'(HT - 1)) && (y == YW'(VT - 1));

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus one scaled, animated, horizontally bouncing sprite fetched
// from an external palette-index ROM (1-cycle latency); drives the VGA PMOD.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   DIR_RIGHT | sprite_x grows by MOVE_STEP each frame, clamps at XMAX
//   DIR_LEFT  | sprite_x shrinks by MOVE_STEP each frame, clamps at 0
module vga_sprite_engine
   import vga_pkg::*;
#(
   parameter  int          H_ACTIVE   = 640,
   parameter  int          H_FP       = 16,
   parameter  int          H_SYNC     = 96,
   parameter  int          H_BP       = 48,
   parameter  int          V_ACTIVE   = 480,
   parameter  int          V_FP       = 10,
   parameter  int          V_SYNC     = 2,
   parameter  int          V_BP       = 33,
   parameter  bit          SYNC_POL   = 1'b0,
   parameter  int          SPRITE_W   = 34,
   parameter  int          SPRITE_H   = 22,
   parameter  int          SCALE_BITS = 3,
   parameter  int          SPRITE_Y   = 128,
   parameter  int          NUM_FRAMES = 2,
   parameter  int          FRAME_DIV  = 16,
   parameter  int          MOVE_STEP  = 2,
   parameter  logic [5:0]  BG_COLOUR  = 6'b000111,
   localparam int          FB = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
   localparam int          YB = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
   localparam int          XB = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
   localparam int          AW = FB + YB + XB
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] rom_addr,
   input  logic [3:0]    rom_data,
   output logic [7:0]    vga_pmod,
   output logic          frame_start
);

   localparam int SW   = SPRITE_W << SCALE_BITS;
   localparam int SH   = SPRITE_H << SCALE_BITS;
   localparam int XMAX = H_ACTIVE - SW;
   localparam int HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW   = $clog2(HT + 1);
   localparam int YW   = $clog2(VT + 1);
   localparam int PW   = XW + 1;
   localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   if (SW > H_ACTIVE) begin : g_err_width
      $error("sprite is wider than the active area");
   end
   if (SPRITE_Y + SH > V_ACTIVE) begin : g_err_height
      $error("sprite extends below the active area");
   end
   if (MOVE_STEP > XMAX) begin : g_err_step
      $error("MOVE_STEP exceeds the horizontal travel range");
   end

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          hsync_on, vsync_on, active, end_of_frame;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk          (clk),
      .rst          (rst),
      .x            (x),
      .y            (y),
      .hsync_on     (hsync_on),
      .vsync_on     (vsync_on),
      .active       (active),
      .end_of_frame (end_of_frame)
   );

   dir_t          dir, dir_next;
   logic [XW-1:0] sprite_x, sprite_x_next;
   logic [PW-1:0] x_inc;
   logic          x_at_max, x_at_min;
   logic [DW-1:0] div_cnt;
   logic [FB-1:0] anim_frame;

   assign x_inc    = {1'b0, sprite_x} + PW'(MOVE_STEP);
   assign x_at_max = x_inc >= PW'(XMAX);
   assign x_at_min = sprite_x <= XW'(MOVE_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         dir      <= DIR_RIGHT;
         sprite_x <= '0;
      end else begin
         dir      <= dir_next;
         sprite_x <= sprite_x_next;
      end
   end

   always_comb begin
      dir_next = dir;
      if (end_of_frame) begin
         case (dir)
            DIR_RIGHT: if (x_at_max) dir_next = DIR_LEFT;
            DIR_LEFT:  if (x_at_min) dir_next = DIR_RIGHT;
            default:   dir_next = DIR_RIGHT;
         endcase
      end
   end

   // Position only moves at end of frame, so a frame never tears.
   always_comb begin
      sprite_x_next = sprite_x;
      if (end_of_frame) begin
         case (dir)
            DIR_RIGHT: sprite_x_next = x_at_max ? XW'(XMAX) : x_inc[XW-1:0];
            DIR_LEFT:  sprite_x_next = x_at_min ? '0 : sprite_x - XW'(MOVE_STEP);
            default:   sprite_x_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         anim_frame <= '0;
      end else if (end_of_frame) begin
         if (div_cnt == DW'(FRAME_DIV - 1)) begin
            div_cnt    <= '0;
            anim_frame <= (anim_frame == FB'(NUM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   logic [XW-1:0] dx;
   logic [YW-1:0] dy;
   logic          hit;
   logic [XB-1:0] tex_x;
   logic [YB-1:0] tex_y;

   assign dx    = x - sprite_x;
   assign dy    = y - YW'(SPRITE_Y);
   assign hit   = (x >= sprite_x) && (dx < XW'(SW)) && (y >= YW'(SPRITE_Y)) && (dy < YW'(SH));
   assign tex_x = XB'(dx >> SCALE_BITS);
   assign tex_y = YB'(dy >> SCALE_BITS);

   logic  s1_hit, s1_active, s1_fs;
   sync_t s1_sync;
   logic  s2_hit, s2_active, s2_fs;
   sync_t s2_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr      <= '0;
         s1_hit        <= 1'b0;
         s1_active     <= 1'b0;
         s1_fs         <= 1'b0;
         s1_sync.hsync <= ~SYNC_POL;
         s1_sync.vsync <= ~SYNC_POL;
         s2_hit        <= 1'b0;
         s2_active     <= 1'b0;
         s2_fs         <= 1'b0;
         s2_sync.hsync <= ~SYNC_POL;
         s2_sync.vsync <= ~SYNC_POL;
      end else begin
         rom_addr      <= hit ? {anim_frame, tex_y, tex_x} : '0;
         s1_hit        <= hit;
         s1_active     <= active;
         s1_fs         <= (x == '0) && (y == '0);
         s1_sync.hsync <= hsync_on ? SYNC_POL : ~SYNC_POL;
         s1_sync.vsync <= vsync_on ? SYNC_POL : ~SYNC_POL;
         s2_hit        <= s1_hit;
         s2_active     <= s1_active;
         s2_fs         <= s1_fs;
         s2_sync       <= s1_sync;
      end
   end

   // rom_data arrives in S2, so colour resolves combinationally from S2 flags.
   rgb_t colour;

   always_comb begin
      colour = '0;
      if (s2_active) begin
         colour = (s2_hit && (rom_data != 4'd0)) ? PALETTE[rom_data] : BG_COLOUR;
      end
   end

   assign vga_pmod    = pmod_pack(colour, s2_sync);
   assign frame_start = s2_fs;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Scoreboard bench for vga_sprite_engine on a reduced video mode with random ROM
// contents and random resets, checked against a raster-level reference model.
module tb_vga_sprite_engine;

   localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
   localparam int VA = 20, VFP = 1, VSY = 2, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int SPW = 4, SPH = 3, SB = 1, SY = 5, NF = 3, FD = 3, STEP = 5;
   localparam int SW = SPW << SB, SH = SPH << SB, XMAX = HA - SW;
   localparam int XB = $clog2(SPW), YB = $clog2(SPH), FB = $clog2(NF);
   localparam int AW = FB + YB + XB;
   localparam logic       POL = 1'b0;
   localparam logic [5:0] BG  = 6'b000111;
   localparam logic [5:0] PAL [16] = '{
      6'h00, 6'h30, 6'h0C, 6'h03, 6'h3C, 6'h33, 6'h0F, 6'h3F,
      6'h15, 6'h2A, 6'h10, 6'h04, 6'h01, 6'h14, 6'h05, 6'h11
   };
   localparam logic [7:0] IDLE = {~POL, 3'b000, ~POL, 3'b000};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rom_addr;
   logic [3:0]    rom_data = 4'd0;
   logic [7:0]    vga_pmod;
   logic          frame_start;

   always #5 clk = ~clk;

   vga_sprite_engine #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SYNC_POL(POL), .SPRITE_W(SPW), .SPRITE_H(SPH), .SCALE_BITS(SB),
      .SPRITE_Y(SY), .NUM_FRAMES(NF), .FRAME_DIV(FD), .MOVE_STEP(STEP),
      .BG_COLOUR(BG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .vga_pmod    (vga_pmod),
      .frame_start (frame_start)
   );

   logic [3:0] rom_mem [1 << AW];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int x; int y; logic [7:0] pmod; logic fs; } pix_t;
   typedef struct { int cyc; int addr; } addr_t;
   typedef struct { int cyc; int sx; int fr; } pos_t;

   pix_t  pix_q [$];
   addr_t addr_q[$];
   pos_t  pos_q [$];

   // Reference raster state: what the DUT counters hold in the current cycle.
   int mx, my, msx, mdir, mfr, mdiv;

   function automatic bit in_sprite(int x, int y, int sx);
      return x >= sx && x < sx + SW && y >= SY && y < SY + SH;
   endfunction

   function automatic int exp_addr(int x, int y, int sx, int fr);
      if (!in_sprite(x, y, sx)) return 0;
      return fr * (1 << (YB + XB)) + ((y - SY) >> SB) * (1 << XB) + ((x - sx) >> SB);
   endfunction

   function automatic logic [7:0] exp_pmod(int x, int y, int sx, int fr);
      logic [5:0] c;
      logic [3:0] d;
      logic       hs, vs;
      hs = (x >= HA + HFP && x < HA + HFP + HSY) ? POL : ~POL;
      vs = (y >= VA + VFP && y < VA + VFP + VSY) ? POL : ~POL;
      c  = 6'd0;
      if (x < HA && y < VA) begin
         d = rom_mem[exp_addr(x, y, sx, fr)];
         c = (in_sprite(x, y, sx) && d != 4'd0) ? PAL[d] : BG;
      end
      return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
   endfunction

   task automatic model_reset();
      mx = 0; my = 0; msx = 0; mdir = 0; mfr = 0; mdiv = 0;
   endtask

   task automatic model_advance();
      if (mx == HT - 1 && my == VT - 1) begin
         if (mdir == 0) begin
            if (msx + STEP >= XMAX) begin msx = XMAX; mdir = 1; end
            else msx = msx + STEP;
         end else begin
            if (msx - STEP <= 0) begin msx = 0; mdir = 0; end
            else msx = msx - STEP;
         end
         if (mdiv == FD - 1) begin mdiv = 0; mfr = (mfr + 1) % NF; end
         else mdiv = mdiv + 1;
      end
      mx = mx + 1;
      if (mx == HT) begin
         mx = 0;
         my = (my == VT - 1) ? 0 : my + 1;
      end
   endtask

   // One clock of stimulus: drive rst, queue the expected responses, advance the model.
   task automatic step(input logic r);
      pix_t  p;
      addr_t a;
      pos_t  s;
      rst = r;
      if (mx == 0 && my == 0) begin
         s.cyc = cyc; s.sx = msx; s.fr = mfr;
         pos_q.push_back(s);
      end
      a.cyc  = cyc + 1;
      a.addr = r ? 0 : exp_addr(mx, my, msx, mfr);
      addr_q.push_back(a);
      if (r) begin
         if (pix_q.size() > 0 && pix_q[$].cyc == cyc + 1) void'(pix_q.pop_back());
         p.x = -1; p.y = -1; p.pmod = IDLE; p.fs = 1'b0;
         p.cyc = cyc + 1; pix_q.push_back(p);
         p.cyc = cyc + 2; pix_q.push_back(p);
         model_reset();
      end else begin
         p.cyc = cyc + 2; p.x = mx; p.y = my;
         p.pmod = exp_pmod(mx, my, msx, mfr);
         p.fs   = (mx == 0 && my == 0);
         pix_q.push_back(p);
         model_advance();
      end
      @(posedge clk);
      #1;
   endtask

   int n_checks = 0;
   int n_fail   = 0;

   always @(negedge clk) begin
      pix_t  p;
      addr_t a;
      pos_t  s;
      while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
         p = pix_q.pop_front();
         n_checks++; n_fail++;
         $display("FAIL pix_missed cyc=%0d expected entry for cyc %0d never compared", cyc, p.cyc);
      end
      if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
         p = pix_q.pop_front();
         n_checks++;
         if (vga_pmod !== p.pmod) begin
            n_fail++;
            $display("FAIL vga_pmod cyc=%0d raster(%0d,%0d) got %b want %b", cyc, p.x, p.y, vga_pmod, p.pmod);
         end
         n_checks++;
         if (frame_start !== p.fs) begin
            n_fail++;
            $display("FAIL frame_start cyc=%0d raster(%0d,%0d) got %b want %b", cyc, p.x, p.y, frame_start, p.fs);
         end
      end
      while (addr_q.size() > 0 && addr_q[0].cyc < cyc) begin
         a = addr_q.pop_front();
         n_checks++; n_fail++;
         $display("FAIL addr_missed cyc=%0d expected entry for cyc %0d never compared", cyc, a.cyc);
      end
      if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
         a = addr_q.pop_front();
         n_checks++;
         if (int'(rom_addr) != a.addr) begin
            n_fail++;
            $display("FAIL rom_addr cyc=%0d got %0d want %0d", cyc, rom_addr, a.addr);
         end
      end
      if (pos_q.size() > 0 && pos_q[0].cyc <= cyc) begin
         s = pos_q.pop_front();
         n_checks++;
         if (int'(dut.sprite_x) != s.sx || int'(dut.anim_frame) != s.fr) begin
            n_fail++;
            $display("FAIL sprite_state cyc=%0d got x=%0d frame=%0d want x=%0d frame=%0d",
                     cyc, dut.sprite_x, dut.anim_frame, s.sx, s.fr);
         end
      end
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rom_mem[(2 << XB) | 3] = 4'h5;
      model_reset();
      @(posedge clk);
      #1;
      repeat (5) step(1'b1);
      // Long uninterrupted run: bounce off both ends and wrap the animation.
      repeat (12 * HT * VT) step(1'b0);
      while (!(mx == 20 && my == 12)) step(1'b0);
      step(1'b1);
      repeat (14 * HT * VT) step(1'b0);
      repeat (10 * HT * VT) step(1'($urandom_range(0, 1499) == 0));
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
